reg8_burst_reader: RTL
======================

Name: reg8_burst_reader

Overview:
- Read-side master for the team's 8-entry x 8-bit 1R1W register file.
- On a start command it drives the register file's read address for a run of consecutive entries and streams the read bytes out on a valid/ready byte stream.
- Supports wrap-around addressing and full output backpressure.
- Sits between the register file read port and any byte-stream consumer, such as a serializer or a debug dump path.

Parameters:
- DWIDTH, 8, data width of a register file entry and of the stream.
- AWIDTH, 3, register file address width; depth is 2**AWIDTH = 8.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle burst request; sampled only in IDLE.
- start_addr  input  AWIDTH  first entry to read.
- len  input  AWIDTH+1  number of entries to read; 0 is a no-op; values above 8 saturate to 8.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the burst completes.
- rf_addr  output  AWIDTH  registered read address to the register file.
- rf_dout  input  DWIDTH  combinational read data from the register file at rf_addr.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream consumer ready.
- m_data  output  DWIDTH  stream byte.
- m_last  output  1  marks the final byte of the burst.

Behaviour:
- Reset values (async on rst_n low, any state including mid-burst): state=IDLE, busy=0, done=0, rf_addr=0, cnt=0, m_valid=0, m_data=0, m_last=0. An in-flight burst is abandoned with no done pulse.
- FSM states: IDLE, RUN, FLUSH.
- IDLE, start=1, effective len L>0:
  - rf_addr<=start_addr, cnt<=min(len,8), busy<=1, go to RUN.
- IDLE, start=1, len=0: go to FLUSH with m_valid=0; done pulses the following cycle; no beats are emitted.
- IDLE, start=0: hold.
- start while busy: ignored, with no effect on the current burst.
- RUN load condition: cnt>0 and (m_valid=0 or m_ready=1). On load:
  - m_data<=rf_dout, m_valid<=1, m_last<=(cnt==1).
  - rf_addr<=rf_addr+1 modulo 8 (7 wraps to 0), cnt<=cnt-1.
- RUN, cnt=0 and m_valid=1 and m_ready=1: m_valid<=0, m_last<=0, go to FLUSH.
- FLUSH: done<=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency:
  - start sampled at edge N; m_valid first high after edge N+1.
  - With m_ready held at 1, one byte per cycle, no bubbles.
  - done visible after the edge following the last handshake.
- Stream rules:
  - m_data and m_last are held stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - m_ready is ignored when m_valid=0.
- Coherency: each byte is the rf_dout value at its load edge. A register file write to an entry after that entry is loaded is not reflected; a write before the load is reflected.
- A burst of 8 starting at any address visits every entry exactly once.

Decomposition:
- Shared package holds:
  - DWIDTH and AWIDTH constants;
  - the depth constant (8);
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2).
- Single flat module; no sub-module is warranted.
- The bench instantiates the existing register file alongside it, with Addr tied to rf_addr and Dout tied to rf_dout.

Test Plan:
- Preload entries k=0..7 with 8'hA0+k; start_addr=2, len=3, m_ready=1.
  - Required: bytes A2,A3,A4 on consecutive cycles; m_last only on A4; done one cycle after the A4 handshake.
- Wrap-around: start_addr=6, len=4.
  - Required: bytes A6,A7,A0,A1; rf_addr sequence 6,7,0,1.
- Backpressure: start_addr=0, len=8, m_ready toggling 1,0,0,1,...
  - Required: all 8 bytes A0..A7 in order, none dropped or duplicated; m_data stable during every stall.
- len=0 returns done with no m_valid; len=12 saturates to 8 bytes.
- start asserted mid-burst: ignored, and the current burst completes unchanged.
- rst_n pulsed low after 2 beats: all outputs 0 immediately with no done pulse; a new burst afterwards behaves normally.

Source files
------------

// File: rtl/reg8_burst_reader_pkg.sv
// ----------------------------------------------------------------------------
// reg8_burst_reader_pkg
//   Shared constants and FSM encoding for the register-file burst reader.
//   RF_DWIDTH : width of one register file entry / stream byte
//   RF_AWIDTH : register file address width
//   RF_DEPTH  : number of register file entries (2**RF_AWIDTH)
//   state_e   : burst reader FSM states
// ----------------------------------------------------------------------------
package reg8_burst_reader_pkg;

    localparam int RF_DWIDTH = 8;
    localparam int RF_AWIDTH = 3;
    localparam int RF_DEPTH  = 1 << RF_AWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/reg8_burst_reader.sv
// ----------------------------------------------------------------------------
// reg8_burst_reader
//   Read-side master for an 8 x 8 1R1W register file. A start command reads a
//   run of consecutive entries (wrapping at the top of the file) and streams
//   the bytes out on a valid/ready interface with full backpressure.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle burst request, only honoured in IDLE
//   start_addr        first entry to read
//   len               entries to read; 0 = no-op, >DEPTH saturates to DEPTH
//   busy              burst in progress (cycle after accept until done)
//   done              one-cycle completion pulse
//   rf_addr           registered read address to the register file
//   rf_dout           combinational read data at rf_addr
//   m_valid/m_ready   stream handshake
//   m_data/m_last     stream byte and end-of-burst marker
// ----------------------------------------------------------------------------
module reg8_burst_reader
    import reg8_burst_reader_pkg::*;
#(
    parameter int DWIDTH = RF_DWIDTH,
    parameter int AWIDTH = RF_AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] rf_addr,
    input  logic [DWIDTH-1:0] rf_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last
);

    localparam logic [AWIDTH:0]   DEPTH_L  = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]   CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    state_e              state_q,   state_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [AWIDTH-1:0]   rf_addr_q, rf_addr_d;
    logic [AWIDTH:0]     cnt_q,     cnt_d;
    logic                m_valid_q, m_valid_d;
    logic [DWIDTH-1:0]   m_data_q,  m_data_d;
    logic                m_last_q,  m_last_d;

    logic [AWIDTH:0]     eff_len;
    logic                load;

    assign eff_len = (len > DEPTH_L) ? DEPTH_L : len;

    // A new byte may be captured whenever the output slot is empty or is
    // being drained this cycle, which gives one byte per cycle under m_ready=1.
    assign load = (cnt_q != '0) && (!m_valid_q || m_ready);

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rf_addr_d = rf_addr_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (len == '0) begin
                        // Empty burst: no beats, just complete via FLUSH.
                        state_d = ST_FLUSH;
                    end else begin
                        rf_addr_d = start_addr;
                        cnt_d     = eff_len;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (load) begin
                    // rf_dout is sampled at the load edge, so later writes to
                    // this entry are not seen by the stream.
                    m_data_d  = rf_dout;
                    m_valid_d = 1'b1;
                    m_last_d  = (cnt_q == CNT_ONE);
                    rf_addr_d = rf_addr_q + ADDR_ONE;
                    cnt_d     = cnt_q - CNT_ONE;
                end else if ((cnt_q == '0) && m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    state_d   = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rf_addr_q <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rf_addr_q <= rf_addr_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rf_addr = rf_addr_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

endmodule
